// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-request FSM type, latency bound, default word width.
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 8;
   localparam int RD_LAT_MAX      = 3;

   typedef enum logic [0:0] {
      RQ_IDLE = 1'b0,
      RQ_PEND = 1'b1
   } rd_req_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Output buffer of the FIFO read stage: circular store, valid/ready handshake and
// sticky overflow detection for captures that find no free slot.
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int BUF_DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DATA_WIDTH-1:0]      wdata,
   input  logic                       m_ready,
   output logic                       m_valid,
   output logic [DATA_WIDTH-1:0]      m_data,
   output logic [$clog2(BUF_DEPTH):0] occupancy,
   output logic                       err_ovf
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic                  err_q, err_d;
   logic                  full, pop, wr, ovf;

   assign full = (occ_q == OCC_W'(BUF_DEPTH));
   assign pop  = m_valid & m_ready;
   // A full buffer still accepts a capture when the head leaves on the same edge.
   assign wr   = push & (~full | pop);
   assign ovf  = push & full & ~pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      err_d    = err_q | ovf;
      if (wr) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         err_q    <= err_d;
      end
   end

   assign m_valid   = (occ_q != '0);
   assign m_data    = mem_q[rd_ptr_q];
   assign occupancy = occ_q;
   assign err_ovf   = err_q;

endmodule

// File: rtl/fifo_rd_stage.sv
// FIFO read-side stage: credit-limited read requests, RD_LAT capture pipe, stream output.
// Define FIFO_RD_STAGE_STATS_EN to add the saturating stall_cnt output.
module fifo_rd_stage
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int RD_LAT     = 1,
   parameter int BUF_DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       fifo_empty,
   input  logic                       ram_en,
   input  logic                       ram_write_en,
   input  logic [DATA_WIDTH-1:0]      ram_rdata,
   output logic                       r_bit,
   output logic                       m_valid,
   output logic [DATA_WIDTH-1:0]      m_data,
   input  logic                       m_ready,
   output logic [$clog2(BUF_DEPTH):0] occupancy,
   output logic                       err_ovf
`ifdef FIFO_RD_STAGE_STATS_EN
   ,
   output logic [15:0]                stall_cnt
`endif
);

   localparam int CNT_W = $clog2(BUF_DEPTH + RD_LAT_MAX + 2) + 1;

   rd_req_t           state_q, state_d;
   logic [RD_LAT-1:0] pipe_q, pipe_d;
   logic [CNT_W-1:0]  inflight;
   logic              rd_issue, capture, credit_ok;

   assign rd_issue = ram_en & ~ram_write_en;
   assign capture  = pipe_q[RD_LAT-1];

   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = rd_issue;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // A pending request already owns a slot, so it counts before its read happens.
   always_comb begin
      inflight = (state_q == RQ_PEND) ? CNT_W'(1) : '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CNT_W'(pipe_q[i]);
      end
   end

   assign credit_ok = (CNT_W'(occupancy) + inflight) < CNT_W'(BUF_DEPTH);

   always_comb begin
      state_d = state_q;
      case (state_q)
         RQ_IDLE: if (!fifo_empty && credit_ok) state_d = RQ_PEND;
         RQ_PEND: if (rd_issue)                 state_d = RQ_IDLE;
         default: state_d = RQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RQ_IDLE;
         pipe_q  <= '0;
      end else begin
         state_q <= state_d;
         pipe_q  <= pipe_d;
      end
   end

   assign r_bit = (state_q == RQ_PEND);

   fifo_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (capture),
      .wdata     (ram_rdata),
      .m_ready   (m_ready),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .occupancy (occupancy),
      .err_ovf   (err_ovf)
   );

`ifdef FIFO_RD_STAGE_STATS_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (m_valid && !m_ready && (stall_q != '1)) stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

endmodule
